// File: rtl/bsg_link_bonded_downstream.sv
// Bonded-link receive side: per-lane FIFOs joined into one wide word.
// Each lane also keeps a decimated credit token counter.
module bsg_link_bonded_downstream #(
    parameter int unsigned channel_width_p                 = 16,
    parameter int unsigned num_channels_p                  = 2,
    parameter int unsigned lg_fifo_depth_p                 = 3,
    parameter int unsigned lg_credit_to_token_decimation_p = 3
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic [num_channels_p-1:0]                  valid_i,
    input  logic [num_channels_p*channel_width_p-1:0]  data_i,
    output logic [num_channels_p-1:0]                  token_r_o,
    output logic [num_channels_p*channel_width_p-1:0]  data_o,
    output logic                                       valid_o,
    input  logic                                       yumi_i,
    output logic [num_channels_p-1:0]                  overflow_r_o
);
    localparam int unsigned depth = 1 << lg_fifo_depth_p;
    localparam int unsigned ptr_w = lg_fifo_depth_p;
    localparam int unsigned cnt_w = lg_fifo_depth_p + 1;
    localparam int unsigned tok_w = lg_credit_to_token_decimation_p + 1;
    localparam logic [cnt_w-1:0] full_cnt = cnt_w'(depth);

    logic [num_channels_p-1:0] not_empty;
    logic                      deq;

    // A bonded word exists only once the slowest lane has data.
    assign valid_o = &not_empty;
    assign deq     = yumi_i & valid_o;

    for (genvar c = 0; c < num_channels_p; c++) begin : g_lane
        logic [channel_width_p-1:0] mem [depth];
        logic [ptr_w-1:0]           rptr;
        logic [ptr_w-1:0]           wptr;
        logic [cnt_w-1:0]           cnt;
        logic [tok_w-1:0]           tok;
        logic                       ovf;
        logic                       full;
        logic                       enq;

        // A full lane still accepts when the same cycle pops a word.
        assign full         = (cnt == full_cnt);
        assign enq          = valid_i[c] & (~full | deq);
        assign not_empty[c] = (cnt != '0);
        assign data_o[c*channel_width_p +: channel_width_p] = mem[rptr];
        assign token_r_o[c]    = tok[tok_w-1];
        assign overflow_r_o[c] = ovf;

        always_ff @(posedge clk_i) begin
            if (reset_n_i && enq) begin
                mem[wptr] <= data_i[c*channel_width_p +: channel_width_p];
            end
        end

        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                rptr <= '0;
                wptr <= '0;
                cnt  <= '0;
                tok  <= '0;
                ovf  <= 1'b0;
            end else begin
                if (enq) begin
                    wptr <= wptr + ptr_w'(1);
                end
                if (deq) begin
                    rptr <= rptr + ptr_w'(1);
                    tok  <= tok + tok_w'(1);
                end
                if (enq && !deq) begin
                    cnt <= cnt + cnt_w'(1);
                end else if (!enq && deq) begin
                    cnt <= cnt - cnt_w'(1);
                end
                if (valid_i[c] && full && !deq) begin
                    ovf <= 1'b1;
                end
            end
        end
    end

endmodule
